// File: rtl/vga_timing_rx.sv
// Recovers pixel coordinates and line/frame geometry from a raw hsync/vsync/data_enable stream and declares lock.
// Latency: data_enable -> pixel_valid/pixel_x/pixel_y is two clk edges; measurements and lock update on the event edge.
// Backpressure: none; the video stream is free-running and every cycle is consumed.
module vga_timing_rx #(
  parameter int EXP_H_TOTAL  = 800,
  parameter int EXP_H_ACTIVE = 640,
  parameter int EXP_V_TOTAL  = 525,
  parameter int EXP_V_ACTIVE = 480,
  parameter int LOCK_FRAMES  = 2,
  parameter int COORD_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   data_enable,
  output logic                   pixel_valid,
  output logic [COORD_WIDTH-1:0] pixel_x,
  output logic [COORD_WIDTH-1:0] pixel_y,
  output logic                   frame_start,
  output logic [COORD_WIDTH-1:0] meas_h_total,
  output logic [COORD_WIDTH-1:0] meas_h_active,
  output logic [COORD_WIDTH-1:0] meas_v_total,
  output logic [COORD_WIDTH-1:0] meas_v_active,
  output logic                   locked,
  output logic                   timing_error
);

  localparam int CW = COORD_WIDTH;
  localparam int MW = $clog2(LOCK_FRAMES + 1) + 1;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] H_TOT   = CW'(EXP_H_TOTAL);
  localparam logic [CW-1:0] H_ACT   = CW'(EXP_H_ACTIVE);
  localparam logic [CW-1:0] V_TOT   = CW'(EXP_V_TOTAL);
  localparam logic [CW-1:0] V_ACT   = CW'(EXP_V_ACTIVE);
  localparam logic [CW-1:0] WD_H    = CW'(2 * EXP_H_TOTAL);
  localparam logic [CW-1:0] WD_V    = CW'(2 * EXP_V_TOTAL);
  localparam logic [MW-1:0] M_ONE   = MW'(1);
  localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic          hs1, hs2, vs1, vs2, de1, de2;
  logic          hfall, vfall, derise, defall;
  logic [CW-1:0] h_cnt, de_cnt, line_cnt, act_cnt;
  logic [CW-1:0] h_meas, line_tot, act_tot;
  logic          h_seen, frame_bad;
  logic          line_bad, de_bad, frame_ok, watchdog;
  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic          locked_nxt, terr_nxt, force_bad;

  // Two-stage input registers; reset to the idle levels so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hs1 <= 1'b1; hs2 <= 1'b1;
      vs1 <= 1'b1; vs2 <= 1'b1;
      de1 <= 1'b0; de2 <= 1'b0;
    end else begin
      hs1 <= hsync;       hs2 <= hs1;
      vs1 <= vsync;       vs2 <= vs1;
      de1 <= data_enable; de2 <= de1;
    end
  end

  // Edge events and the per-event checks derived from the running counters.
  always_comb begin
    hfall    = hs2 & ~hs1;
    vfall    = vs2 & ~vs1;
    derise   = de1 & ~de2;
    defall   = de2 & ~de1;
    h_meas   = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + ONE;
    // a sync edge landing on the frame-closing cycle still belongs to the frame being closed
    line_tot = hfall ? line_cnt + ONE : line_cnt;
    act_tot  = defall ? act_cnt + ONE : act_cnt;
    line_bad = hfall & h_seen & (h_meas != H_TOT);
    de_bad   = defall & (de_cnt != H_ACT);
    frame_ok = ~(frame_bad | line_bad | de_bad) & (line_tot == V_TOT) & (act_tot == V_ACT);
    watchdog = (state != SEARCH) & ((h_cnt == WD_H) | (line_cnt == WD_V));
  end

  // Active-area coordinates, aligned with the registered data_enable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      pixel_valid <= de1;
      if (derise)         pixel_x <= '0;
      else if (de1 & de2) pixel_x <= pixel_x + ONE;
      if (vfall)          pixel_y <= '0;
      else if (defall)    pixel_y <= pixel_y + ONE;
    end
  end

  // Line/frame geometry counters; the watchdog restarts them from scratch.
  always_ff @(posedge clk) begin
    if (!resetn || watchdog) begin
      h_cnt    <= '0;
      de_cnt   <= '0;
      line_cnt <= '0;
      act_cnt  <= '0;
      h_seen   <= 1'b0;
    end else begin
      if (hfall)                        h_cnt <= '0;
      else if (h_cnt != CNT_MAX)        h_cnt <= h_cnt + ONE;
      if (defall)                       de_cnt <= '0;
      else if (de1 && de_cnt != CNT_MAX) de_cnt <= de_cnt + ONE;
      if (vfall)                        line_cnt <= '0;
      else if (hfall)                   line_cnt <= line_cnt + ONE;
      if (vfall)                        act_cnt <= '0;
      else if (defall)                  act_cnt <= act_cnt + ONE;
      // the first hfall only opens a line; its partial length is never checked
      if (hfall)                        h_seen <= 1'b1;
    end
  end

  // Published measurements and the frame pulse; measurements survive a watchdog.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meas_h_total  <= '0;
      meas_h_active <= '0;
      meas_v_total  <= '0;
      meas_v_active <= '0;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= vfall;
      if (hfall)  meas_h_total  <= h_meas;
      if (defall) meas_h_active <= de_cnt;
      if (vfall) begin
        meas_v_total  <= line_tot;
        meas_v_active <= act_tot;
      end
    end
  end

  // Sticky per-frame error flag, consumed and cleared at each vfall.
  always_ff @(posedge clk) begin
    if (!resetn)                             frame_bad <= 1'b0;
    else if (vfall)                          frame_bad <= 1'b0;
    else if (force_bad | line_bad | de_bad)  frame_bad <= 1'b1;
  end

  // Lock FSM state and its registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= SEARCH;
      match_cnt    <= '0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      state        <= state_nxt;
      match_cnt    <= match_nxt;
      locked       <= locked_nxt;
      timing_error <= terr_nxt;
    end
  end

  // Lock FSM next state: count matching frames, drop on the first mismatch, watchdog overrides all.
  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    locked_nxt = locked;
    terr_nxt   = 1'b0;
    force_bad  = 1'b0;
    case (state)
      SEARCH: begin
        locked_nxt = 1'b0;
        if (vfall) begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
      end
      MEASURE: begin
        if (vfall) begin
          if (!frame_ok) begin
            match_nxt = '0;
          end else if ((match_cnt + M_ONE) >= LOCK_N) begin
            state_nxt  = LOCKED;
            match_nxt  = '0;
            locked_nxt = 1'b1;
          end else begin
            match_nxt = match_cnt + M_ONE;
          end
        end
      end
      LOCKED: begin
        if (line_bad | de_bad | (vfall & ~frame_ok)) begin
          state_nxt  = MEASURE;
          match_nxt  = '0;
          locked_nxt = 1'b0;
          terr_nxt   = 1'b1;
          // a mid-frame loss poisons the frame in progress; at vfall that frame has just closed
          force_bad  = ~vfall;
        end
      end
      default: begin
        state_nxt  = SEARCH;
        locked_nxt = 1'b0;
      end
    endcase
    if (watchdog) begin
      state_nxt  = SEARCH;
      match_nxt  = '0;
      locked_nxt = 1'b0;
      terr_nxt   = 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a reduced 20x10 mode (12x6 active) so whole frames stay short.
// Drives a small sync generator, compares against hand-computed measurements and lock timing.
// No flow control on the DUT; the generator advances every clock.
module tb_vga_timing_rx;

  localparam int HT = 20, HA = 12, VT = 10, VA = 6, LF = 2, CW = 16;

  logic          clk, resetn, hsync, vsync, data_enable;
  logic          pixel_valid, frame_start, locked, timing_error;
  logic [CW-1:0] pixel_x, pixel_y, meas_h_total, meas_h_active, meas_v_total, meas_v_active;

  vga_timing_rx #(
    .EXP_H_TOTAL(HT), .EXP_H_ACTIVE(HA), .EXP_V_TOTAL(VT), .EXP_V_ACTIVE(VA),
    .LOCK_FRAMES(LF), .COORD_WIDTH(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
    .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
    .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
    .locked(locked), .timing_error(timing_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit de; bit hs; bit vs; int hc; int vc; } drv_t;
  typedef struct {
    int htot; int hact; int vtot; int vact;
    int e_mht; int e_mha; int e_mvt; int e_mva; int e_lock; int e_te;
  } vec_t;

  int   n_vec, n_bad;
  // generator state: hc/vc is the position driven on the next tick
  int   g_htot, g_hact, g_vtot, g_vact, hc, vc;
  bit   armed;
  int   tgt_vc, ovr_htot, ovr_hact, hs_hold;
  drv_t cur, prev;
  // monitor state
  int   fs_cnt, te_cnt, te_fs, te_locked, te_mht, te_mha, prev_locked;
  int   lock_at[8], lock_prev_at[8];
  bit   chk_coord, cap_en;
  int   px_seen, last_px;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic gen_step();
    int ht, ha;
    ht = (armed && vc == tgt_vc && ovr_htot != 0) ? ovr_htot : g_htot;
    ha = (armed && vc == tgt_vc && ovr_hact != 0) ? ovr_hact : g_hact;
    cur.hc = hc;
    cur.vc = vc;
    cur.de = (hc < ha) && (vc < g_vact);
    cur.hs = !(hc >= g_hact + 2 && hc < g_hact + 5);
    cur.vs = !(vc >= g_vact + 1 && vc < g_vact + 3);
    if (hs_hold > 0) begin
      cur.hs = 1'b1;
      hs_hold--;
    end
    hsync = cur.hs; vsync = cur.vs; data_enable = cur.de;
    if (hc == ht - 1) begin
      hc = 0;
      if (armed && vc == tgt_vc) armed = 1'b0;
      vc = (vc == g_vtot - 1) ? 0 : vc + 1;
    end else begin
      hc++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_coord) begin
      chk("pixel_valid", pixel_valid, prev.de);
      if (prev.de) begin
        chk("pixel_x", pixel_x, prev.hc);
        chk("pixel_y", pixel_y, prev.vc);
        px_seen++;
      end
    end
    if (cap_en && te_cnt == 0 && pixel_valid && pixel_y == 2) last_px = pixel_x;
    if (frame_start) begin
      fs_cnt++;
      if (fs_cnt < 8) begin
        lock_at[fs_cnt]      = locked;
        lock_prev_at[fs_cnt] = prev_locked;
      end
    end
    if (timing_error) begin
      te_cnt++;
      te_fs     = fs_cnt;
      te_locked = locked;
      te_mht    = meas_h_total;
      te_mha    = meas_h_active;
    end
    prev_locked = locked;
    prev = cur;
    gen_step();
  endtask

  task automatic clr();
    fs_cnt = 0; te_cnt = 0; te_fs = -1; te_locked = 9; te_mht = -1; te_mha = -1;
    for (int i = 0; i < 8; i++) begin
      lock_at[i] = 9;
      lock_prev_at[i] = 9;
    end
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  task automatic run_fs(input int k, input int budget);
    int t = 0;
    while (fs_cnt < k && t < budget) begin
      tick();
      t++;
    end
    chk("frame_starts_within_budget", fs_cnt, k);
  endtask

  task automatic wait_gen(input int v, input int h);
    int t = 0;
    while (!(hc == h && vc == v) && t < 1000) begin
      tick();
      t++;
    end
    chk("generator_position_reached", (hc == h && vc == v), 1);
  endtask

  task automatic chk_all_zero();
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_x", pixel_x, 0);
    chk("rst_pixel_y", pixel_y, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_meas_h_total", meas_h_total, 0);
    chk("rst_meas_h_active", meas_h_active, 0);
    chk("rst_meas_v_total", meas_v_total, 0);
    chk("rst_meas_v_active", meas_v_active, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timing_error", timing_error, 0);
  endtask

  task automatic set_mode(input int ht, input int ha, input int vt, input int va);
    g_htot = ht; g_hact = ha; g_vtot = vt; g_vact = va;
    hc = 0; vc = 0; armed = 1'b0; hs_hold = 0;
  endtask

  vec_t tbl[5];

  initial begin
    // geometry table: {htot, hact, vtot, vact, exp meas h_tot/h_act/v_tot/v_act, exp locked, exp error pulses}
    tbl[0] = '{20, 12, 10, 6, 20, 12, 10, 6, 1, 0};  // nominal mode
    tbl[1] = '{21, 12, 10, 6, 21, 12, 10, 6, 0, 0};  // one extra back-porch clock per line
    tbl[2] = '{20, 11, 10, 6, 20, 11, 10, 6, 0, 0};  // active run one short
    tbl[3] = '{20, 12, 11, 6, 20, 12, 11, 6, 0, 0};  // one extra blank line
    tbl[4] = '{20, 12, 10, 5, 20, 12, 10, 5, 0, 0};  // one active line missing

    n_vec = 0; n_bad = 0;
    chk_coord = 1'b0; cap_en = 1'b0; px_seen = 0; last_px = -1; prev_locked = 0;
    tgt_vc = 0; ovr_htot = 0; ovr_hact = 0;
    resetn = 1'b0; hsync = 1'b1; vsync = 1'b1; data_enable = 1'b0;
    cur = '{de: 1'b0, hs: 1'b1, vs: 1'b1, hc: 0, vc: 0};
    prev = cur;
    set_mode(HT, HA, VT, VA);
    clr();

    // reset state
    repeat (3) tick();
    chk_all_zero();

    // measurement and lock outcome per geometry
    for (int i = 0; i < 5; i++) begin
      set_mode(tbl[i].htot, tbl[i].hact, tbl[i].vtot, tbl[i].vact);
      do_reset(3);
      clr();
      run_fs(5, 3000);
      chk($sformatf("row%0d_meas_h_total", i), meas_h_total, tbl[i].e_mht);
      chk($sformatf("row%0d_meas_h_active", i), meas_h_active, tbl[i].e_mha);
      chk($sformatf("row%0d_meas_v_total", i), meas_v_total, tbl[i].e_mvt);
      chk($sformatf("row%0d_meas_v_active", i), meas_v_active, tbl[i].e_mva);
      chk($sformatf("row%0d_locked", i), locked, tbl[i].e_lock);
      chk($sformatf("row%0d_error_pulses", i), te_cnt, tbl[i].e_te);
    end

    // nominal lock timing: locked appears together with the 3rd frame_start
    set_mode(HT, HA, VT, VA);
    do_reset(3);
    clr();
    run_fs(3, 2000);
    chk("nom_lock_at_fs1", lock_at[1], 0);
    chk("nom_lock_at_fs2", lock_at[2], 0);
    chk("nom_lock_before_fs3", lock_prev_at[3], 0);
    chk("nom_lock_at_fs3", lock_at[3], 1);
    chk("nom_error_pulses", te_cnt, 0);

    // coordinate sweep over one full locked frame
    chk_coord = 1'b1; px_seen = 0;
    clr();
    run_fs(1, 400);
    chk_coord = 1'b0;
    chk("nom_pixels_per_frame", px_seen, HA * VA);
    chk("nom_locked_kept", locked, 1);
    chk("nom_error_pulses_frame", te_cnt, 0);

    // hsync stuck high past twice the line length: watchdog back to SEARCH
    wait_gen(1, 0);
    hs_hold = 45;
    clr();
    run_fs(3, 3000);
    chk("wd_error_pulses", te_cnt, 1);
    chk("wd_pulse_before_vsync", te_fs, 0);
    chk("wd_locked_at_pulse", te_locked, 0);
    chk("wd_meas_h_total_kept", te_mht, 20);
    chk("wd_lock_at_fs1", lock_at[1], 0);
    chk("wd_lock_at_fs2", lock_at[2], 0);
    chk("wd_lock_at_fs3", lock_at[3], 1);

    // one line shortened by a clock
    wait_gen(0, 0);
    armed = 1'b1; tgt_vc = 2; ovr_htot = 19; ovr_hact = 0;
    clr();
    run_fs(3, 3000);
    chk("short_error_pulses", te_cnt, 1);
    chk("short_pulse_before_vsync", te_fs, 0);
    chk("short_locked_at_pulse", te_locked, 0);
    chk("short_meas_h_total", te_mht, 19);
    chk("short_lock_at_fs1", lock_at[1], 0);
    chk("short_lock_at_fs2", lock_at[2], 0);
    chk("short_lock_at_fs3", lock_at[3], 1);

    // one active run a pixel short
    wait_gen(0, 0);
    armed = 1'b1; tgt_vc = 2; ovr_htot = 0; ovr_hact = 11;
    cap_en = 1'b1; last_px = -1;
    clr();
    run_fs(3, 3000);
    cap_en = 1'b0;
    chk("de_error_pulses", te_cnt, 1);
    chk("de_locked_at_pulse", te_locked, 0);
    chk("de_meas_h_active", te_mha, 11);
    chk("de_last_pixel_x", last_px, 10);
    chk("de_lock_at_fs2", lock_at[2], 0);
    chk("de_lock_at_fs3", lock_at[3], 1);

    // reset mid active line
    wait_gen(2, 5);
    resetn = 1'b0;
    tick();
    chk_all_zero();
    tick();
    tick();
    resetn = 1'b1;
    clr();
    repeat (10) tick();
    chk("rel_frame_start_pulses", fs_cnt, 0);
    chk("rel_error_pulses", te_cnt, 0);
    run_fs(3, 2000);
    chk("rel_lock_at_fs2", lock_at[2], 0);
    chk("rel_lock_at_fs3", lock_at[3], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the display timing generator. Accepts a raw hsync/vsync/data_enable stream from the on-chip generator or an external video source.
- Recovers active-area pixel coordinates, measures the line and frame geometry, and declares lock once the stream matches the expected mode.
- Feeds the capture/loopback path and the self-test status register.

Parameters:
EXP_H_TOTAL, 800, expected clocks per line (hsync fall to hsync fall)
EXP_H_ACTIVE, 640, expected data_enable-high clocks per active line
EXP_V_TOTAL, 525, expected lines per frame (hsync falls between vsync falls)
EXP_V_ACTIVE, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive fully matching frames required to lock (>=1)
COORD_WIDTH, 16, width of coordinate and measurement outputs

Ports:
clk  in  1  pixel clock
resetn  in  1  reset
hsync  in  1  horizontal sync, active-low
vsync  in  1  vertical sync, active-low
data_enable  in  1  active video qualifier
pixel_valid  out  1  registered data_enable, aligned with pixel_x/pixel_y
pixel_x  out  COORD_WIDTH  column within the active line, unsigned
pixel_y  out  COORD_WIDTH  active line index within the frame, unsigned
frame_start  out  1  one-cycle pulse on each vsync falling edge
meas_h_total  out  COORD_WIDTH  last measured line length
meas_h_active  out  COORD_WIDTH  last measured data_enable run length
meas_v_total  out  COORD_WIDTH  last measured lines per frame
meas_v_active  out  COORD_WIDTH  last measured active lines per frame
locked  out  1  stream matches the expected mode
timing_error  out  1  one-cycle pulse on loss of lock or watchdog expiry

Behaviour:
- Reset is synchronous, active-low, on clock clk (already decided). While resetn is low, at every edge:
  - all outputs are 0;
  - the stage registers hs1/hs2/vs1/vs2 are set to 1 (idle) and de1/de2 to 0, so no spurious edge is seen on release;
  - the FSM goes to SEARCH.
- Input pipeline: hs1<=hsync, vs1<=vsync, de1<=data_enable; hs2<=hs1, vs2<=vs1, de2<=de1.
  - Events: hfall = hs2&~hs1; vfall = vs2&~vs1; derise = de1&~de2; defall = de2&~de1.
- Coordinates (all registered on the same edge):
  - pixel_valid<=de1.
  - pixel_x<=0 on derise; pixel_x+1 when de1&de2; otherwise hold.
  - pixel_y<=0 on vfall; pixel_y+1 on defall; otherwise hold.
  - vfall and defall on the same cycle: vfall wins, pixel_y<=0.
  - Latency: data_enable sampled at edge k produces pixel_valid after edge k+1.
- Horizontal measurement:
  - h_cnt increments every cycle and saturates at all-ones. On hfall: meas_h_total<=h_cnt+1, h_cnt<=0.
  - de_cnt counts de1-high cycles. On defall: meas_h_active<=de_cnt, de_cnt<=0.
  - A line measurement is valid only after one prior hfall since entering SEARCH. The first partial line is ignored for checks but meas_h_total is still written.
- Vertical measurement:
  - line_cnt increments on hfall; act_cnt increments on defall.
  - On vfall: meas_v_total<=line_cnt and meas_v_active<=act_cnt, then both are zeroed. A coincident hfall is counted before closing, so the captured value includes it.
  - frame_start<=vfall.
- Per-frame sticky flag frame_bad is set by:
  - any valid line with h_total != EXP_H_TOTAL;
  - any defall with de_cnt != EXP_H_ACTIVE.
  - frame_bad is cleared at each vfall after being evaluated.
  - Frame match = !frame_bad, line_cnt == EXP_V_TOTAL and act_cnt == EXP_V_ACTIVE, all evaluated at vfall.
- FSM:
  - SEARCH: locked=0. On the first vfall go to MEASURE with match_cnt=0; that first partial frame is discarded.
  - MEASURE: at each vfall, a match increments match_cnt and a mismatch clears it. When match_cnt reaches LOCK_FRAMES, go to LOCKED; locked is 1 after that edge.
  - LOCKED: on any valid line mismatch (at its hfall or defall), or on a frame mismatch at vfall:
    - locked<=0, timing_error pulse;
    - go to MEASURE with match_cnt=0 and frame_bad=1, so the current frame cannot count.
- Watchdog, active in every state except SEARCH:
  - h_cnt reaching 2*EXP_H_TOTAL, or line_cnt reaching 2*EXP_V_TOTAL, forces SEARCH.
  - Also: locked<=0, a timing_error pulse, and h_cnt/line_cnt/de_cnt/act_cnt cleared.
  - The meas_* outputs keep their last values.
- Reset mid-frame: everything is reinitialised as above, and lock requires LOCK_FRAMES+1 vfalls again.

Test Plan:
1. Drive from the timing generator at default parameters, released from reset with this block -> meas_h_total=800, meas_h_active=640, meas_v_total=525, meas_v_active=480; locked rises one cycle after the 3rd vfall; pixel_x sweeps 0..639 and pixel_y 0..479 exactly while pixel_valid=1.
2. Generator with H_BACK_PORCH=49 (line 801 clocks) -> meas_h_total=801; locked never asserts; timing_error never pulses (no lock, no watchdog).
3. After lock, hold hsync high for 1600 cycles -> timing_error single pulse; locked=0; FSM in SEARCH; meas_h_total unchanged at 800. Restore the stream -> relock after 3 vfalls.
4. After lock, shorten one line to 799 clocks -> at that hfall: locked falls and timing_error pulses once; the current frame is not counted; relock after LOCK_FRAMES further clean frames.
5. After lock, one active line with data_enable high 639 cycles -> meas_h_active=639, locked drops at that defall; pixel_x last value 638 on that line.
6. Assert resetn low for 3 cycles mid-active-line -> all outputs 0 on the next edge; no frame_start or timing_error pulse on release; relock after 3 vfalls.
